riscv_muldiv_sequencer: RTL and testbench

- Multi-cycle controller for the RV32M execute path.
- Accepts one M-extension op at a time from the pipeline, latches the operands and drives them stably into the signed/unsigned operand converter.
- Issues the op to either the fixed-latency pipelined multiplier or the start/done iterative divider, then captures the converted result.
- Resolves RISC-V divide-by-zero and signed-overflow cases locally, without using the divider, and holds the result until writeback accepts it.

---
 rtl/riscv_muldiv_sequencer.sv | 174 +++++++++++++++++
 tb/tb_riscv_muldiv_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_muldiv_sequencer.sv
// riscv_muldiv_sequencer: multi-cycle RV32M controller driving a pipelined multiplier,
// an iterative start/done divider and a shared signed/unsigned operand converter.
module riscv_muldiv_sequencer #(
    parameter int MULT_LATENCY = 2,
    parameter int DIV_TIMEOUT  = 64
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_func3_i,
    input  logic [31:0] req_src1_i,
    input  logic [31:0] req_src2_i,
    input  logic [4:0]  req_rd_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_result_o,
    output logic [4:0]  resp_rd_o,
    output logic        busy_o,
    output logic [2:0]  conv_func3_o,
    output logic [31:0] conv_src1_o,
    output logic [31:0] conv_src2_o,
    input  logic [31:0] conv_result_i,
    output logic        mult_en_o,
    output logic        div_start_o,
    input  logic        div_done_i,
    output logic        err_timeout_o
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] MUL_ISSUE = 3'd1;
    localparam logic [2:0] MUL_WAIT  = 3'd2;
    localparam logic [2:0] DIV_CHECK = 3'd3;
    localparam logic [2:0] DIV_START = 3'd4;
    localparam logic [2:0] DIV_WAIT  = 3'd5;
    localparam logic [2:0] DIV_DRAIN = 3'd6;
    localparam logic [2:0] RESP      = 3'd7;
    localparam int TW = $clog2(DIV_TIMEOUT + 1);

    logic [2:0]    state;
    logic [2:0]    func3;
    logic [31:0]   src1;
    logic [31:0]   src2;
    logic [4:0]    rd;
    logic [31:0]   result;
    logic [3:0]    mul_cnt;
    logic [TW-1:0] div_cnt;
    logic          check_done;
    logic          special;
    logic          err_timeout;
    logic          accept;
    logic          div_expired;
    logic          is_zero;
    logic          is_ovf;
    logic [31:0]   special_result;

    assign accept      = req_valid_i & req_ready_o;
    assign div_expired = div_cnt == TW'(DIV_TIMEOUT - 1);

    // func3[0]=0 selects the signed DIV/REM; func3[1]=1 selects the remainder
    assign is_zero        = src2 == '0;
    assign is_ovf         = ~func3[0] & (src1 == 32'h8000_0000) & (src2 == '1);
    assign special_result = is_zero ? (func3[1] ? src1 : '1) : (func3[1] ? '0 : 32'h8000_0000);

    assign req_ready_o   = (state == IDLE) & ~flush_i;
    assign mult_en_o     = (state == MUL_ISSUE) & ~flush_i;
    assign div_start_o   = (state == DIV_START) & ~flush_i;
    assign resp_valid_o  = state == RESP;
    assign resp_result_o = result;
    assign resp_rd_o     = rd;
    assign busy_o        = state != IDLE;
    assign conv_func3_o  = func3;
    assign conv_src1_o   = src1;
    assign conv_src2_o   = src2;
    assign err_timeout_o = err_timeout;

    // Op sequencing: latch on accept, issue to mul/div, capture, hold until writeback
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state       <= IDLE;
            func3       <= '0;
            src1        <= '0;
            src2        <= '0;
            rd          <= '0;
            result      <= '0;
            mul_cnt     <= '0;
            div_cnt     <= '0;
            check_done  <= 1'b0;
            special     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        func3      <= req_func3_i;
                        src1       <= req_src1_i;
                        src2       <= req_src2_i;
                        rd         <= req_rd_i;
                        check_done <= 1'b0;
                        state      <= req_func3_i[2] ? DIV_CHECK : MUL_ISSUE;
                    end
                end
                MUL_ISSUE: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        mul_cnt <= 4'(MULT_LATENCY);
                        state   <= MUL_WAIT;
                    end
                end
                MUL_WAIT: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else if (mul_cnt == '0) begin
                        result <= conv_result_i;
                        state  <= RESP;
                    end else begin
                        mul_cnt <= mul_cnt - 4'd1;
                    end
                end
                // First cycle registers the special-case classification, second cycle branches on it
                DIV_CHECK: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else if (!check_done) begin
                        check_done <= 1'b1;
                        special    <= is_zero | is_ovf;
                        result     <= special_result;
                    end else begin
                        state <= special ? RESP : DIV_START;
                    end
                end
                // A flush here suppresses the start strobe, so no divider op is pending to drain
                DIV_START: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        div_cnt <= '0;
                        state   <= DIV_WAIT;
                    end
                end
                // A done coinciding with a flush has already retired the divider op, so skip the drain
                DIV_WAIT: begin
                    if (div_done_i) begin
                        result <= conv_result_i;
                        state  <= flush_i ? IDLE : RESP;
                    end else if (div_expired) begin
                        err_timeout <= 1'b1;
                        result      <= '0;
                        state       <= flush_i ? IDLE : RESP;
                    end else begin
                        div_cnt <= div_cnt + TW'(1);
                        if (flush_i) state <= DIV_DRAIN;
                    end
                end
                // Drain shares the timeout budget started in DIV_WAIT
                DIV_DRAIN: begin
                    if (div_done_i) begin
                        state <= IDLE;
                    end else if (div_expired) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + TW'(1);
                    end
                end
                RESP: begin
                    if (flush_i || resp_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_muldiv_sequencer.sv
// tb_riscv_muldiv_sequencer: scoreboard bench with RV32M reference model, multiplier and divider models
module tb_riscv_muldiv_sequencer;
    localparam int ML = 2;
    localparam int DT = 64;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_func3_i = '0;
    logic [31:0] req_src1_i = '0;
    logic [31:0] req_src2_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [31:0] resp_result_o;
    logic [4:0]  resp_rd_o;
    logic        busy_o;
    logic [2:0]  conv_func3_o;
    logic [31:0] conv_src1_o;
    logic [31:0] conv_src2_o;
    logic [31:0] conv_result_i;
    logic        mult_en_o;
    logic        div_start_o;
    logic        div_done_i;
    logic        err_timeout_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_lat = -1;
    int acc_cyc = 0;
    int rise_cyc = 0;
    int n_rise = 0;
    int n_mult = 0;
    int n_div = 0;
    int start_cyc = 0;
    int div_cnt = 0;
    int div_lat = 10;
    logic [15:0] mpipe = '0;
    logic        bp_mode = 1'b0;
    logic        ready_fixed = 1'b1;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_res = '0;
    logic [4:0]  prev_rd = '0;
    logic [36:0] mon_e;
    logic [36:0] exp_q[$];

    riscv_muldiv_sequencer #(.MULT_LATENCY(ML), .DIV_TIMEOUT(DT)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_func3_i(req_func3_i),
        .req_src1_i(req_src1_i), .req_src2_i(req_src2_i), .req_rd_i(req_rd_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_result_o(resp_result_o), .resp_rd_o(resp_rd_o), .busy_o(busy_o),
        .conv_func3_o(conv_func3_o), .conv_src1_o(conv_src1_o), .conv_src2_o(conv_src2_o),
        .conv_result_i(conv_result_i), .mult_en_o(mult_en_o), .div_start_o(div_start_o),
        .div_done_i(div_done_i), .err_timeout_o(err_timeout_o)
    );

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        r = '0;
        p = '0;
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: if (b == 0) r = '1; else begin p = sa / sb; r = p[31:0]; end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always #5 clock_i = ~clock_i;

    // Multiplier pipeline and divider behaviour as seen through the converter
    always @(posedge clock_i) begin
        cyc <= cyc + 1;
        mpipe <= {mpipe[14:0], mult_en_o};
        n_mult <= n_mult + (mult_en_o ? 1 : 0);
        if (div_start_o) begin
            div_cnt <= div_lat;
            start_cyc <= cyc + 1;
            n_div <= n_div + 1;
        end else if (div_cnt > 0) begin
            div_cnt <= div_cnt - 1;
        end
    end

    assign div_done_i = div_cnt == 1;
    assign conv_result_i = (mpipe[ML] || div_done_i) ? ref_op(conv_func3_o, conv_src1_o, conv_src2_o) : 32'hDEAD_BEEF;

    initial forever begin
        @(posedge clock_i);
        #2;
        resp_ready_i = bp_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // Monitor: latency, hold-while-stalled and scoreboard pop on every delivered response
    always @(negedge clock_i) begin
        if (reset_i) begin
            if (resp_valid_o && !prev_valid) begin
                n_rise <= n_rise + 1;
                rise_cyc <= cyc;
                if (exp_lat >= 0) check("resp_latency", 64'(cyc - acc_cyc), 64'(exp_lat));
            end
            if (resp_valid_o && prev_valid) check("resp_hold", {resp_rd_o, resp_result_o}, {prev_rd, prev_res});
            if (resp_valid_o) check("ready_in_resp", req_ready_o, 0);
            if (resp_valid_o && resp_ready_i && !flush_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got result %0h with empty scoreboard", resp_result_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_result", resp_result_o, mon_e[31:0]);
                    check("resp_rd", resp_rd_o, mon_e[36:32]);
                end
            end
        end
        prev_valid <= resp_valid_o & reset_i;
        prev_res <= resp_result_o;
        prev_rd <= resp_rd_o;
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic push, input logic [31:0] exp_res);
        int n = 0;
        req_func3_i = f;
        req_src1_i = a;
        req_src2_i = b;
        req_rd_i = rd;
        req_valid_i = 1'b1;
        while (!req_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("accept_bound", 64'(n), 0);
        tick();
        acc_cyc = cyc;
        if (push) exp_q.push_back({rd, exp_res});
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        logic bad = 1'b0;
        while (busy_o && n < 300) begin
            if ({conv_func3_o, conv_src1_o, conv_src2_o} !== {f, a, b}) bad = 1'b1;
            tick();
            n++;
        end
        check("idle_bound", busy_o, 0);
        check("conv_stable", bad, 0);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        exp_lat = !f[2] ? ML + 2 : (is_special(f, a, b) ? 2 : -1);
        send(f, a, b, rd, 1'b1, ref_op(f, a, b));
        wait_idle(f, a, b);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, d0, r0, n;
        logic bad;
        logic [2:0] f;
        logic [31:0] a, b;
        repeat (3) tick();
        check("reset_outs", {req_ready_o, resp_valid_o, busy_o, mult_en_o, div_start_o, err_timeout_o}, 64'b100000);
        check("reset_conv", {conv_func3_o, conv_src1_o}, 0);
        check("reset_resp", {conv_src2_o, resp_rd_o}, 0);
        check("reset_result", resp_result_o, 0);
        reset_i = 1'b1;
        tick();

        m0 = n_mult;
        exp_lat = ML + 2;
        send(3'd0, 7, 6, 5'd9, 1'b1, 42);
        check("mul_strobe", mult_en_o, 1);
        check("ready_after_accept", req_ready_o, 0);
        tick();
        check("mul_strobe_len", mult_en_o, 0);
        wait_idle(3'd0, 7, 6);
        check("mul_issue_count", 64'(n_mult - m0), 1);

        div_lat = 10;
        d0 = n_div;
        exp_lat = -1;
        send(3'd5, 100, 7, 5'd3, 1'b1, 14);
        wait_idle(3'd5, 100, 7);
        send(3'd7, 100, 7, 5'd4, 1'b1, 2);
        wait_idle(3'd7, 100, 7);
        check("div_start_count", 64'(n_div - d0), 2);

        d0 = n_div;
        exp_lat = 2;
        send(3'd4, 32'hFFFF_FFFB, 0, 5'd10, 1'b1, 32'hFFFF_FFFF);
        wait_idle(3'd4, 32'hFFFF_FFFB, 0);
        send(3'd7, 32'h1234, 0, 5'd11, 1'b1, 32'h1234);
        wait_idle(3'd7, 32'h1234, 0);
        send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1, 32'h8000_0000);
        wait_idle(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1, 0);
        wait_idle(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        check("special_no_start", 64'(n_div - d0), 0);

        ready_fixed = 1'b0;
        exp_lat = ML + 2;
        send(3'd1, 32'hFFFF_FFFD, 5, 5'd7, 1'b1, 32'hFFFF_FFFF);
        n = 0;
        while (!resp_valid_o && n < 50) begin
            tick();
            n++;
        end
        repeat (5) begin
            check("bp_valid_held", resp_valid_o, 1);
            check("bp_result_held", resp_result_o, 32'hFFFF_FFFF);
            tick();
        end
        ready_fixed = 1'b1;
        wait_idle(3'd1, 32'hFFFF_FFFD, 5);

        r0 = n_rise;
        exp_lat = -1;
        send(3'd0, 3, 4, 5'd1, 1'b0, 0);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_mul_idle", busy_o, 0);
        repeat (ML + 4) tick();
        check("flush_mul_no_resp", 64'(n_rise - r0), 0);

        div_lat = 15;
        d0 = n_div;
        r0 = n_rise;
        send(3'd5, 1000, 3, 5'd2, 1'b0, 0);
        n = 0;
        while (n_div == d0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        bad = 1'b0;
        n = 0;
        while (!div_done_i && n < 50) begin
            if (!busy_o) bad = 1'b1;
            tick();
            n++;
        end
        check("drain_busy", bad, 0);
        check("drain_busy_at_done", busy_o, 1);
        tick();
        check("drain_idle", busy_o, 0);
        check("drain_no_resp", 64'(n_rise - r0), 0);
        check("drain_one_start", 64'(n_div - d0), 1);

        bp_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 100); b = $urandom_range(1, 9); end
                default: ;
            endcase
            div_lat = $urandom_range(1, 12);
            run_op(f, a, b, 5'($urandom_range(0, 31)));
        end
        bp_mode = 1'b0;
        ready_fixed = 1'b1;

        div_lat = 0;
        exp_lat = -1;
        send(3'd5, 50, 5, 5'd6, 1'b1, 0);
        wait_idle(3'd5, 50, 5);
        check("timeout_flag", err_timeout_o, 1);
        check("timeout_cycles", 64'(rise_cyc - start_cyc), 64'(DT));

        div_lat = 10;
        run_op(3'd0, 9, 9, 5'd1);
        check("timeout_sticky", err_timeout_o, 1);
        check("sb_empty", 64'(exp_q.size()), 0);
        reset_i = 1'b0;
        tick();
        check("timeout_cleared", err_timeout_o, 0);
        reset_i = 1'b1;
        tick();
        check("idle_after_reset", {req_ready_o, busy_o}, 64'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
